// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, state encoding and opcode classing for the control sequencer
package cpu_ctrl_pkg;

  localparam int OP_W_PKG = 5;

  localparam logic [OP_W_PKG-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W_PKG-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W_PKG-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W_PKG-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W_PKG-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W_PKG-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W_PKG-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W_PKG-1:0] OP_SHL  = 5'b01000;
  localparam logic [OP_W_PKG-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W_PKG-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W_PKG-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W_PKG-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W_PKG-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W_PKG-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W_PKG-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W_PKG-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LD, C_ST, C_MULDIV, C_JR, C_NOP, C_HALT, C_ILL
  } op_class_t;

  // Groups opcodes that share an execute sequence.
  function automatic op_class_t classify(input logic [OP_W_PKG-1:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: c = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:                      c = C_IMM;
      OP_LD:                                         c = C_LD;
      OP_ST:                                         c = C_ST;
      OP_MUL, OP_DIV:                                c = C_MULDIV;
      OP_JR:                                         c = C_JR;
      OP_NOP:                                        c = C_NOP;
      OP_HALT:                                       c = C_HALT;
      default:                                       c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_timer.sv
// rtl/cpu_control_sequencer_timer.sv - memory wait counter that flags a stuck Read/Write
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clr || !active || ready) count <= '0;
    else                         count <= count + 1'b1;
  end

  // Fires on the wait cycle that would bring the count to MEM_TIMEOUT.
  assign expired = active && !ready && (count == LAST);

endmodule

// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - Moore control unit sequencing fetch/execute strobes for the bus datapath
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W        = OP_W_PKG,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            Read,
  output logic            Write,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            fault,
  output logic            illegal
);

  state_t    state, next;
  op_class_t cls;
  logic      mem_wait, expired, done;
  logic      stop_q, t1_stay;

  assign cls      = classify(opcode);
  assign mem_wait = (state == T1) || (state == T6 && cls == C_LD) || (state == T7 && cls == C_ST);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timer (
    .clk    (clk),
    .clr    (clr),
    .active (mem_wait),
    .ready  (mem_ready),
    .expired(expired)
  );

  // stop is latched so a pulse mid-instruction still halts at the boundary.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= T0;
      fault   <= 1'b0;
      stop_q  <= 1'b0;
      t1_stay <= 1'b0;
    end else begin
      state   <= next;
      stop_q  <= (stop_q || stop) && !done;
      t1_stay <= (state == T1) && (next == T1);
      if (expired) fault <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    done = 1'b0;
    case (state)
      T0: next = T1;
      T1: begin
        if (expired)        next = HALTED;
        else if (mem_ready) next = T2;
      end
      T2: begin
        case (cls)
          C_NOP:   done = 1'b1;
          C_HALT:  next = HALTED;
          default: next = T3;
        endcase
      end
      T3: begin
        if (cls == C_JR || cls == C_ILL) done = 1'b1;
        else                             next = T4;
      end
      T4: next = T5;
      T5: begin
        if (cls == C_ALU || cls == C_IMM) done = 1'b1;
        else                              next = T6;
      end
      T6: begin
        if (cls == C_MULDIV)                  done = 1'b1;
        else if (expired)                     next = HALTED;
        else if (mem_ready || !mem_wait)      next = T7;
      end
      T7: begin
        if (expired)                          next = HALTED;
        else if (mem_ready || !mem_wait)      done = 1'b1;
      end
      default: next = HALTED;
    endcase
    if (done) next = (stop || stop_q) ? HALTED : T0;
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0;
    LOin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op  = '0;
    illegal = 1'b0;
    run     = !clr && (state != HALTED);
    if (!clr) begin
      case (state)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        T1: begin
          // PC is loaded once; the rest is held for the length of the read.
          Zlowout = 1'b1; PCin = !t1_stay; Read = 1'b1; MDRin = 1'b1;
        end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: begin
          case (cls)
            C_ALU, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_LD, C_ST:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            C_MULDIV:     begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_JR:         begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            C_ILL:        illegal = 1'b1;
            default:      ;
          endcase
        end
        T4: begin
          case (cls)
            C_ALU:       begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            C_IMM:       begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            C_LD, C_ST:  begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
            C_MULDIV:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
            default:     ;
          endcase
        end
        T5: begin
          case (cls)
            C_ALU, C_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_LD, C_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
            C_MULDIV:     begin Zlowout = 1'b1; LOin = 1'b1; end
            default:      ;
          endcase
        end
        T6: begin
          case (cls)
            C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
            C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
            default:  ;
          endcase
        end
        T7: begin
          case (cls)
            C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_ST:    Write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
